// File: rtl/apb_master_if.sv
`default_nettype none
// ============================================================================
// apb_master_if : command/response port and APB requester bus of apb_master
// Revision      : 1.0 - initial release
// ============================================================================
interface apb_master_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;

  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;

  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface
`default_nettype wire

// File: rtl/apb_master.sv
`default_nettype none
// ============================================================================
// apb_master : valid/ready command to single APB SETUP/ACCESS transfer
// Revision   : 1.0 - initial release
// ============================================================================
module apb_master #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          PCLK,
  input  logic          PRESET,
  apb_master_if.master  bus
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          timeout_hit;
  logic          pwrite_q, pwrite_d;
  logic [AW-1:0] paddr_q, paddr_d;
  logic [DW-1:0] pwdata_q, pwdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;
  logic          rsp_timeout_q, rsp_timeout_d;

  // Wait counter exists only when a timeout is configured; it saturates at the abort point.
  if (TIMEOUT != 0) begin : g_timeout
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);
    logic [CW-1:0] wait_q, wait_d;

    always_comb begin
      wait_d = wait_q;
      if (state_q == S_SETUP)
        wait_d = '0;
      else if (state_q == S_ACCESS && !bus.PREADY)
        wait_d = wait_q + CW'(1);
    end

    always_ff @(posedge PCLK) begin
      if (PRESET) wait_q <= '0;
      else        wait_q <= wait_d;
    end

    assign timeout_hit = (state_q == S_ACCESS) && !bus.PREADY && (wait_q == C_LAST);
  end else begin : g_no_timeout
    assign timeout_hit = 1'b0;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.cmd_valid) state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: if (bus.PREADY || timeout_hit) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready = (state_q == S_IDLE) && !PRESET;
    bus.PSEL      = (state_q == S_SETUP) || (state_q == S_ACCESS);
    bus.PENABLE   = (state_q == S_ACCESS);
  end

  always_comb begin
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    if (state_q == S_IDLE && bus.cmd_valid) begin
      pwrite_d = bus.cmd_write;
      paddr_d  = bus.cmd_addr;
      if (bus.cmd_write) pwdata_d = bus.cmd_wdata;
    end
    if (state_q == S_ACCESS) begin
      if (bus.PREADY) begin
        rsp_valid_d   = 1'b1;
        rsp_rdata_d   = pwrite_q ? '0 : bus.PRDATA;
        rsp_err_d     = bus.PSLVERR;
        rsp_timeout_d = 1'b0;
      end else if (timeout_hit) begin
        rsp_valid_d   = 1'b1;
        rsp_rdata_d   = '0;
        rsp_err_d     = 1'b1;
        rsp_timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus.PWRITE      = pwrite_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
endmodule
`default_nettype wire

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB requester that drives the slave side of the GPIO bridge (PSEL/PENABLE/PWRITE/PADDR/PWDATA) and collects PRDATA/PREADY.
- Turns a simple valid/ready command port into exactly one APB SETUP→ACCESS transfer per command.
- Returns a single-cycle response carrying read data, slave error and timeout status.
- Sits between a CPU/test sequencer and the APB GPIO bridge.

Parameters:
- AW, 32, PADDR/cmd_addr width.
- DW, 32, PWDATA/PRDATA/cmd_wdata/rsp_rdata width.
- TIMEOUT, 16, consecutive ACCESS cycles with PREADY low before abort; 0 disables timeout.

Ports:
- PCLK  in  1  clock, all logic rising-edge.
- PRESET  in  1  synchronous active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  AW  transfer address.
- cmd_wdata  in  DW  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DW  read data (0 for writes and aborts).
- rsp_err  out  1  PSLVERR sampled at completion, or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  AW  APB address.
- PWDATA  out  DW  APB write data.
- PRDATA  in  DW  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB slave error.

Behaviour:
- Clock/reset: one clock, PCLK. Reset PRESET is synchronous and active-high.
- Reset state: on any rising edge with PRESET=1, go to IDLE.
  - All outputs 0: PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, rsp_timeout.
  - Wait counter cleared.
- cmd_ready = (state==IDLE) && !PRESET, combinational. No command FIFO.
- FSM states IDLE, SETUP, ACCESS:
  - IDLE:
    - On cmd_valid && cmd_ready at an edge, register cmd_write→PWRITE, cmd_addr→PADDR, cmd_wdata→PWDATA.
    - PSEL←1, PENABLE←0; go to SETUP.
    - For reads, PWDATA keeps its previous value.
  - SETUP: lasts exactly one cycle. Next edge: PENABLE←1, go to ACCESS, clear wait counter.
  - ACCESS, completion: at an edge with PREADY=1:
    - PSEL←0, PENABLE←0.
    - rsp_valid←1 for one cycle.
    - rsp_rdata←PWRITE ? 0 : PRDATA.
    - rsp_err←PSLVERR, rsp_timeout←0.
    - Go to IDLE.
  - ACCESS, wait: at an edge with PREADY=0, increment the wait counter.
    - If TIMEOUT≠0 and the count reaches TIMEOUT: PSEL←0, PENABLE←0, rsp_valid←1, rsp_rdata←0, rsp_err←1, rsp_timeout←1, go to IDLE.
- Signal stability:
  - PADDR/PWRITE/PWDATA are stable from SETUP through the end of ACCESS.
  - After completion they hold their last values until the next accepted command.
- Response hold:
  - rsp_rdata, rsp_err and rsp_timeout hold until the next response.
  - rsp_valid is high for exactly one cycle per accepted command.
- Latency:
  - Accept at edge E0; SETUP in cycle E0..E1; ACCESS from E1.
  - With zero wait states, response is visible after E2.
  - cmd_ready returns high in the same cycle as rsp_valid.
  - Minimum command-to-command spacing is 3 cycles.
  - Each PREADY=0 cycle adds one cycle.
- PREADY and PSLVERR are ignored outside ACCESS.
- cmd_valid while cmd_ready=0 is ignored. The requester must hold the command until accepted.
- Reset mid-transfer: PSEL/PENABLE drop on that edge and the transfer is abandoned with no rsp_valid.
- Counter width is clog2(TIMEOUT+1). No wrap: the count saturates at the abort point.

Test Plan:
- Zero-wait write:
  - Stimulus: PREADY=1, write addr 0xFFFF_0F0F, data 201.
  - Response: PSEL=1/PENABLE=0 for 1 cycle, then PENABLE=1 for 1 cycle with PWDATA=0x0000_00C9 throughout.
  - Then rsp_valid=1, rsp_rdata=0, rsp_err=0. cmd_ready low exactly 2 cycles.
- Wait-state read:
  - Stimulus: read addr 0xF0F0_FFFF, PREADY low 3 ACCESS cycles then high with PRDATA=201.
  - Response: PENABLE high 4 cycles, PADDR constant; rsp_rdata=201, rsp_err=0.
- Slave error:
  - Stimulus: read with PREADY=1, PSLVERR=1, PRDATA=0xDEAD_BEEF.
  - Response: rsp_err=1, rsp_timeout=0, rsp_rdata=0xDEAD_BEEF.
- Timeout:
  - Stimulus: TIMEOUT=16, PREADY held 0.
  - Response: PENABLE high exactly 16 cycles, then PSEL=PENABLE=0, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - Repeat with TIMEOUT=0: PENABLE stays high indefinitely (≥100 cycles) until PREADY=1.
- Back-to-back:
  - Stimulus: cmd_valid held high with 4 writes (addr 0x0,0x4,0x8,0xC), PREADY=1.
  - Response: 4 rsp_valid pulses, 3 cycles apart. PSEL low exactly 1 cycle between transfers, addresses in order.
- Reset mid-ACCESS:
  - Stimulus: assert PRESET for 1 cycle while PENABLE=1 and PREADY=0.
  - Response: next edge all outputs 0, no rsp_valid. cmd_ready=1 the cycle after PRESET falls.
  - A new read completes normally afterwards.
